// File: rtl/aabb_slab_reducer_if.sv
// Bundle between the slab reducer, its requester and the external
// greater_than FP comparator. Every FP bus is [width:0] in FloPoCo 11/21
// format. The slave modport is the reducer's view; the master modport is the
// environment's view (requester plus comparator).
interface aabb_slab_reducer_if #(
    parameter int width = 34
);
    logic             start;
    logic [width:0]   tnear_x;
    logic [width:0]   tnear_y;
    logic [width:0]   tnear_z;
    logic [width:0]   tfar_x;
    logic [width:0]   tfar_y;
    logic [width:0]   tfar_z;
    logic [width:0]   cmp_a;
    logic [width:0]   cmp_b;
    logic             cmp_gt;
    logic             busy;
    logic             done;
    logic             hit;
    logic [width:0]   tmin_out;
    logic [width:0]   tmax_out;

    modport slave (
        input  start, tnear_x, tnear_y, tnear_z, tfar_x, tfar_y, tfar_z, cmp_gt,
        output cmp_a, cmp_b, busy, done, hit, tmin_out, tmax_out
    );

    modport master (
        output start, tnear_x, tnear_y, tnear_z, tfar_x, tfar_y, tfar_z, cmp_gt,
        input  cmp_a, cmp_b, busy, done, hit, tmin_out, tmax_out
    );
endinterface

// File: rtl/aabb_slab_reducer.sv
// aabb_slab_reducer: sequences one external greater_than FP comparator through
// the dependent compares of a ray/AABB slab test and reduces the six slab
// distances to tmin = max(tnear), tmax = min(tfar), hit = (tmin <= tmax).
//
// Optional feature macro: RAABB_TMAX_POS_CHECK_EN
//   defined   -> adds a sixth compare (tmax > 0); a box behind the ray misses.
//   undefined -> five compares, hit = !miss.
//
// Per step: one ISSUE cycle plus CMP_LAT WAIT cycles. The operands for a step
// are registered on the edge that enters ISSUE, so the comparator result is
// valid in the last WAIT cycle and is consumed on the edge leaving WAIT. The
// STEP update is applied on that same edge, so it has no cycle of its own;
// operands of the following step are forwarded from the freshly updated
// tmin/tmax values.
module aabb_slab_reducer #(
    parameter int CMP_LAT = 4,
    parameter int width   = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    aabb_slab_reducer_if.slave    bus
);

`ifdef RAABB_TMAX_POS_CHECK_EN
    localparam int NSTEPS = 6;
`else
    localparam int NSTEPS = 5;
`endif

    localparam logic [width:0] FP_ZERO   = {(width + 1){1'b0}};
    localparam logic [3:0]     WAIT_LAST = 4'(CMP_LAT - 1);
    localparam logic [2:0]     STEP_LAST = 3'(NSTEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q,    state_d;
    logic [2:0]      step_q,     step_d;
    logic [3:0]      wait_q,     wait_d;
    logic [width:0]  tnx_q,      tnx_d;
    logic [width:0]  tny_q,      tny_d;
    logic [width:0]  tnz_q,      tnz_d;
    logic [width:0]  tfx_q,      tfx_d;
    logic [width:0]  tfy_q,      tfy_d;
    logic [width:0]  tfz_q,      tfz_d;
    logic [width:0]  tmin_q,     tmin_d;
    logic [width:0]  tmax_q,     tmax_d;
    logic            miss_q,     miss_d;
    logic            pos_q,      pos_d;
    logic [width:0]  cmp_a_q,    cmp_a_d;
    logic [width:0]  cmp_b_q,    cmp_b_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            hit_q,      hit_d;
    logic [width:0]  tmin_out_q, tmin_out_d;
    logic [width:0]  tmax_out_q, tmax_out_d;

    // Next-state, datapath update and operand selection for the reduction FSM.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        wait_d     = wait_q;
        tnx_d      = tnx_q;
        tny_d      = tny_q;
        tnz_d      = tnz_q;
        tfx_d      = tfx_q;
        tfy_d      = tfy_q;
        tfz_d      = tfz_q;
        tmin_d     = tmin_q;
        tmax_d     = tmax_q;
        miss_d     = miss_q;
        pos_d      = pos_q;
        cmp_a_d    = cmp_a_q;
        cmp_b_d    = cmp_b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hit_d      = hit_q;
        tmin_out_d = tmin_out_q;
        tmax_out_d = tmax_out_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    tnx_d   = bus.tnear_x;
                    tny_d   = bus.tnear_y;
                    tnz_d   = bus.tnear_z;
                    tfx_d   = bus.tfar_x;
                    tfy_d   = bus.tfar_y;
                    tfz_d   = bus.tfar_z;
                    step_d  = 3'd0;
                    busy_d  = 1'b1;
                    // Step 0 operands come straight from the request bus.
                    cmp_a_d = bus.tnear_y;
                    cmp_b_d = bus.tnear_x;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                wait_d  = 4'd0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    // Consume the comparator result for the current step.
                    case (step_q)
                        3'd0: tmin_d = bus.cmp_gt ? tny_q : tnx_q;
                        3'd1: tmin_d = bus.cmp_gt ? tnz_q : tmin_q;
                        3'd2: tmax_d = bus.cmp_gt ? tfy_q : tfx_q;
                        3'd3: tmax_d = bus.cmp_gt ? tfz_q : tmax_q;
                        3'd4: miss_d = bus.cmp_gt;
                        3'd5: pos_d  = bus.cmp_gt;
                        default: miss_d = miss_q;
                    endcase

                    if (step_q == STEP_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = ST_ISSUE;
                        // Next step operands, forwarded from updated bounds.
                        case (step_d)
                            3'd1: begin cmp_a_d = tnz_q;  cmp_b_d = tmin_d; end
                            3'd2: begin cmp_a_d = tfx_q;  cmp_b_d = tfy_q;  end
                            3'd3: begin cmp_a_d = tmax_d; cmp_b_d = tfz_q;  end
                            3'd4: begin cmp_a_d = tmin_d; cmp_b_d = tmax_d; end
                            3'd5: begin cmp_a_d = tmax_d; cmp_b_d = FP_ZERO; end
                            default: begin cmp_a_d = tny_q; cmp_b_d = tnx_q; end
                        endcase
                    end
                end else begin
                    wait_d  = wait_q + 4'd1;
                    state_d = ST_WAIT;
                end
            end

            ST_DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
`ifdef RAABB_TMAX_POS_CHECK_EN
                hit_d      = !miss_q && pos_q;
`else
                hit_d      = !miss_q;
`endif
                tmin_out_d = tmin_q;
                tmax_out_d = tmax_q;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= 3'd0;
            wait_q     <= 4'd0;
            tnx_q      <= FP_ZERO;
            tny_q      <= FP_ZERO;
            tnz_q      <= FP_ZERO;
            tfx_q      <= FP_ZERO;
            tfy_q      <= FP_ZERO;
            tfz_q      <= FP_ZERO;
            tmin_q     <= FP_ZERO;
            tmax_q     <= FP_ZERO;
            miss_q     <= 1'b0;
            pos_q      <= 1'b0;
            cmp_a_q    <= FP_ZERO;
            cmp_b_q    <= FP_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            tmin_out_q <= FP_ZERO;
            tmax_out_q <= FP_ZERO;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wait_q     <= wait_d;
            tnx_q      <= tnx_d;
            tny_q      <= tny_d;
            tnz_q      <= tnz_d;
            tfx_q      <= tfx_d;
            tfy_q      <= tfy_d;
            tfz_q      <= tfz_d;
            tmin_q     <= tmin_d;
            tmax_q     <= tmax_d;
            miss_q     <= miss_d;
            pos_q      <= pos_d;
            cmp_a_q    <= cmp_a_d;
            cmp_b_q    <= cmp_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            tmin_out_q <= tmin_out_d;
            tmax_out_q <= tmax_out_d;
        end
    end

    assign bus.cmp_a    = cmp_a_q;
    assign bus.cmp_b    = cmp_b_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hit      = hit_q;
    assign bus.tmin_out = tmin_out_q;
    assign bus.tmax_out = tmax_out_q;

endmodule
